// File: rtl/regfile_dbg_access.sv
// Debug initiator for the integer register file: halts the core, runs one read/write/dump, returns beats.
// Latency: accept -> rsp_valid in 3 cycles minimum (1 cycle for rejected ops); a dump streams one beat per 2 cycles.
// Backpressure: cmd_ready only in IDLE; each response beat is held stable until rsp_ready. Build option REGFILE_DBG_DUMP_EN enables op 10.
module regfile_dbg_access #(
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_reg,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_reg,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        halt_req,
  input  logic        halted,
  output logic        dbg_active,
  output logic [4:0]  rf_read_reg,
  input  logic [31:0] rf_read_data,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic        rf_write_enable
);

  typedef enum logic [1:0] {IDLE = 2'd0, HALT_WAIT = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;

  localparam logic [1:0]  OP_WRITE     = 2'b01;
`ifdef REGFILE_DBG_DUMP_EN
  localparam logic [1:0]  OP_DUMP      = 2'b10;
`endif
  // Last count value spent in HALT_WAIT before giving up on the halt handshake.
  localparam logic [15:0] TIMEOUT_LAST = 16'(HALT_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [4:0]  idx_q;
  logic [31:0] wdata_q;
  logic [15:0] cnt_q;
  logic        halt_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic        cmd_halts;   // incoming op needs the core halted (legal op)
  logic        dump_more;   // current beat is a non-final dump beat

`ifdef REGFILE_DBG_DUMP_EN
  assign cmd_halts = (cmd_op != 2'b11);
  assign dump_more = (op_q == OP_DUMP) && !rsp_err_q && (idx_q != 5'd31);
`else
  assign cmd_halts = (cmd_op[1] == 1'b0);
  assign dump_more = 1'b0;
`endif

  assign rsp_reg  = idx_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign halt_req = halt_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and register-file port drive; the write strobe is masked by reset.
  always_comb begin
    state_d         = state_q;
    cmd_ready       = 1'b0;
    rsp_valid       = 1'b0;
    dbg_active      = 1'b0;
    rf_read_reg     = 5'd0;
    rf_write_reg    = 5'd0;
    rf_write_data   = 32'd0;
    rf_write_enable = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = cmd_halts ? HALT_WAIT : RESP;
      end
      HALT_WAIT: begin
        if (halted)                     state_d = ACCESS;
        else if (cnt_q == TIMEOUT_LAST) state_d = RESP;
      end
      ACCESS: begin
        dbg_active = 1'b1;
        state_d    = RESP;
        if (op_q == OP_WRITE) begin
          rf_write_reg    = idx_q;
          rf_write_data   = wdata_q;
          rf_write_enable = (idx_q != 5'd0) && !rst;
        end else begin
          rf_read_reg = idx_q;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = dump_more ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, halt timeout counter, response capture and dump index stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= 2'd0;
      idx_q      <= 5'd0;
      wdata_q    <= 32'd0;
      cnt_q      <= 16'd0;
      halt_q     <= 1'b0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q       <= cmd_op;
`ifdef REGFILE_DBG_DUMP_EN
            idx_q      <= (cmd_op == OP_DUMP) ? 5'd0 : cmd_reg;
`else
            idx_q      <= cmd_reg;
`endif
            wdata_q    <= cmd_data;
            cnt_q      <= 16'd0;
            halt_q     <= cmd_halts;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= !cmd_halts;
          end
        end
        HALT_WAIT: begin
          cnt_q <= cnt_q + 16'd1;
          if (!halted && cnt_q == TIMEOUT_LAST) begin
            rsp_err_q  <= 1'b1;
            rsp_data_q <= 32'd0;
          end
        end
        ACCESS: begin
          rsp_err_q  <= 1'b0;
          rsp_data_q <= (op_q == OP_WRITE) ? 32'd0 : rf_read_data;
        end
        RESP: begin
          if (rsp_ready) begin
`ifdef REGFILE_DBG_DUMP_EN
            if (dump_more) idx_q  <= idx_q + 5'd1;
            else           halt_q <= 1'b0;
`else
            halt_q <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dbg_access.sv
// Bench for regfile_dbg_access: register-file model, halt/ready agents, queue scoreboard.
// Expected beats come from an architectural register array updated on each issued command.
// Monitor pops the queue on every rsp handshake; stimulus checks latency and halt release.
module tb_regfile_dbg_access;
  localparam int TO = 4;
`ifdef REGFILE_DBG_DUMP_EN
  localparam bit DUMP = 1'b1;
`else
  localparam bit DUMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [4:0]  cmd_reg = 5'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_reg;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        halt_req;
  logic        halted;
  logic        dbg_active;
  logic [4:0]  rf_read_reg;
  logic [31:0] rf_read_data;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_write_enable;

  always #5 clk = ~clk;

  regfile_dbg_access #(.HALT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_reg(rsp_reg), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .halt_req(halt_req), .halted(halted), .dbg_active(dbg_active),
    .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data), .rf_write_enable(rf_write_enable)
  );

  // External register file: combinational read, registered write (x0 storage is real so stray writes show up).
  logic [31:0] rf_mem [32] = '{default: 32'h0};
  assign rf_read_data = rf_mem[rf_read_reg];
  always @(posedge clk) if (rf_write_enable) rf_mem[rf_write_reg] <= rf_write_data;

  typedef struct packed {logic [4:0] r; logic [31:0] d; logic e;} beat_t;
  beat_t       exp_q[$];
  beat_t       held, popped;
  logic [31:0] ref_regs [32];

  int checks = 0, errors = 0;
  int cyc = 0, accept_cyc = 0, exp_lat = 0;
  int first_rsp_cyc = -1, last_we_cyc = -1, we_cnt = 0;
  bit beat_pending = 1'b0;
  int halt_mode = 1, halt_delay = 0, hcnt = 0;   // 0 never halts, 1 tied high, 2 follows halt_req after delay
  bit hold_low = 1'b0, rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, why);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Core halt agent.
  initial begin
    halted = 1'b0;
    forever begin
      @(posedge clk); #1;
      hcnt = halt_req ? hcnt + 1 : 0;
      case (halt_mode)
        1:       halted = 1'b1;
        2:       halted = halt_req && (hcnt > halt_delay);
        default: halted = 1'b0;
      endcase
    end
  end

  // Response consumer.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rsp_ready = hold_low ? 1'b0 : (rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  // Monitor: scoreboard pops, beat stability, halt never raised while idle.
  always @(negedge clk) begin
    if (rst) begin
      beat_pending = 1'b0;
    end else begin
      if (rf_write_enable) begin
        we_cnt++;
        last_we_cyc = cyc;
      end
      if (cmd_ready) chk("halt_req_idle", {63'd0, halt_req}, 64'd0);
      if (rsp_valid) begin
        if (!beat_pending && first_rsp_cyc < 0) first_rsp_cyc = cyc;
        if (beat_pending) chk("rsp_stable", {26'd0, rsp_reg, rsp_data, rsp_err}, {26'd0, held});
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            fail("rsp_unexpected", $sformatf("beat reg=%0d data=%0h err=%0b with nothing expected", rsp_reg, rsp_data, rsp_err));
          end else begin
            popped = exp_q.pop_front();
            chk("rsp_beat", {26'd0, rsp_reg, rsp_data, rsp_err}, {26'd0, popped});
          end
          beat_pending = 1'b0;
        end else begin
          beat_pending = 1'b1;
          held = {rsp_reg, rsp_data, rsp_err};
        end
      end else if (beat_pending) begin
        fail("rsp_dropped", "rsp_valid fell before handshake");
        beat_pending = 1'b0;
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_ctrl"}, {43'd0, cmd_ready, rsp_valid, rsp_err, halt_req, dbg_active, rf_write_enable,
                         rsp_reg, rf_read_reg, rf_write_reg}, {43'd0, 1'b1, 20'd0});
    chk({tag, "_data"}, {rsp_data, rf_write_data}, 64'd0);
  endtask

  // Issue one command; when track is set, push the architecturally expected beats and update the model.
  task automatic issue(input logic [1:0] op, input logic [4:0] r, input logic [31:0] d, input bit track);
    int n = 0;
    bit halting, tout;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    if (!cmd_ready) fail("cmd_ready_wait", "block never became ready");
    halting = (op == 2'd0) || (op == 2'd1) || (DUMP && op == 2'd2);
    tout    = halting && (halt_mode == 0);
    if (!halting)            exp_lat = 1;
    else if (tout)           exp_lat = 1 + TO;
    else if (halt_mode == 2) exp_lat = 3 + halt_delay;
    else                     exp_lat = 3;
    if (track) begin
      if (!halting)   exp_q.push_back({r, 32'h0, 1'b1});
      else if (tout)  exp_q.push_back({(op == 2'd2) ? 5'd0 : r, 32'h0, 1'b1});
      else if (op == 2'd0) exp_q.push_back({r, ref_regs[r], 1'b0});
      else if (op == 2'd1) begin
        exp_q.push_back({r, 32'h0, 1'b0});
        if (r != 5'd0) ref_regs[r] = d;
      end else begin
        for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), ref_regs[i], 1'b0});
      end
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_reg = r; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_reg = 5'($urandom); cmd_data = $urandom;
    accept_cyc = cyc;
    first_rsp_cyc = -1;
    chk("halt_req_t1", {63'd0, halt_req}, {63'd0, halting});
    chk("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
  endtask

  // Wait for the first beat (latency check) and for return to IDLE (halt released).
  task automatic finish_cmd(input string name);
    int n = 0;
    while (first_rsp_cyc < 0 && n < 200) begin @(negedge clk); n++; end
    if (first_rsp_cyc < 0) fail({name, "_rsp"}, "no response beat within 200 cycles");
    else chk({name, "_lat"}, 64'(first_rsp_cyc - accept_cyc + 1), 64'(exp_lat));
    n = 0;
    while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
    if (!cmd_ready) fail({name, "_done"}, "block never returned to idle");
    else chk({name, "_halt_drop"}, {63'd0, halt_req}, 64'd0);
  endtask

  task automatic run(input logic [1:0] op, input logic [4:0] r, input logic [31:0] d, input string name);
    issue(op, r, d, 1'b1);
    finish_cmd(name);
  endtask

  initial begin
    int we0, n, sel;
    logic [31:0] v;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("reset");

    // Write then read x5 with halted tied high.
    halt_mode = 1;
    we0 = we_cnt;
    run(2'd1, 5'd5, 32'hDEADBEEF, "wr_x5");
    chk("wr_x5_we_count", 64'(we_cnt - we0), 64'd1);
    chk("wr_x5_we_lat", 64'(last_we_cyc - accept_cyc + 1), 64'd2);
    run(2'd0, 5'd5, 32'h0, "rd_x5");

    // x0 write must not strobe the port; read back is zero.
    we0 = we_cnt;
    run(2'd1, 5'd0, 32'h12345678, "wr_x0");
    chk("wr_x0_we_count", 64'(we_cnt - we0), 64'd0);
    run(2'd0, 5'd0, 32'h0, "rd_x0");

    // Halt timeout, then a late halt.
    run(2'd1, 5'd1, $urandom, "wr_x1");
    halt_mode = 0;
    run(2'd0, 5'd1, 32'h0, "rd_x1_timeout");
    halt_mode = 2; halt_delay = 2;
    run(2'd0, 5'd1, 32'h0, "rd_x1_late_halt");

    // Illegal op: immediate error beat, no halt.
    halt_mode = 1;
    run(2'd3, 5'd9, 32'h0, "illegal");

    // Backpressure on a read of x3.
    run(2'd1, 5'd3, $urandom, "wr_x3");
    hold_low = 1'b1;
    issue(2'd0, 5'd3, 32'h0, 1'b1);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (!rsp_valid) fail("bp_valid", "no beat under backpressure");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", {24'd0, rsp_valid, cmd_ready, halt_req, rsp_reg, rsp_data}, {24'd0, 1'b1, 1'b0, 1'b1, 5'd3, ref_regs[3]});
    end
    hold_low = 1'b0;
    finish_cmd("bp_read");

    // Preload xN = N*0x11 under random stalls, then dump.
    rand_rdy = 1'b1;
    halt_mode = 2;
    for (int i = 1; i < 32; i++) begin
      halt_delay = int'($urandom_range(0, 2));
      run(2'd1, 5'(i), 32'(i * 32'h11), "preload");
    end
    halt_delay = 1;
    run(2'd2, 5'd0, 32'h0, "dump");
    chk("dump_drained", 64'(exp_q.size()), 64'd0);

    // Random traffic against the model.
    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 9));
      halt_mode  = (sel == 9) ? 0 : int'($urandom_range(1, 2));
      halt_delay = int'($urandom_range(0, 2));
      v = $urandom;
      if (sel < 4 || sel == 9) run(2'd0, 5'($urandom), 32'h0, "rand_rd");
      else if (sel < 8)        run(2'd1, 5'($urandom), v, "rand_wr");
      else                     run(2'd3, 5'($urandom), v, "rand_ill");
    end

    // Reset during the ACCESS cycle of a write to x7.
    rand_rdy = 1'b0;
    halt_mode = 1;
    issue(2'd1, 5'd7, 32'hFF, 1'b0);
    @(posedge clk); #1;
    chk("rst_in_access", {63'd0, dbg_active}, 64'd1);
    rst = 1'b1;
    #1 chk("rst_we_gated", {63'd0, rf_write_enable}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset("mid_reset");
    exp_q.delete();
    run(2'd0, 5'd7, 32'h0, "rd_x7_after_reset");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
